// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the parametrised data memory family.
package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_t;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 5;

endpackage

// File: rtl/dmem_byte_ram.sv
// Storage array: one clocked byte-lane write port and one registered read port.
// ADDR_W here must equal $clog2(DEPTH); callers slice wider addresses down.
module dmem_byte_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // rd_zero lets the caller return zero for addresses that have no storage behind them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_zero) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/param_data_memory.sv
// Parametrised data memory with req/ack handshake, byte enables, range check and post-reset zero sweep.
// Optional access counters (rd_cnt/wr_cnt) are built when DMEM_ACCESS_CNT_EN is defined.
module param_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 32,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_d_in,
  input  logic [BE_W-1:0]   mem_be,
  output logic              mem_ready,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_d_out,
  output logic              mem_err
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W does not truncate to zero.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  dmem_state_t state, next_state;
  logic [IDX_W-1:0] sweep_cnt;
  logic sweep_last, accept, in_range;
  logic ram_wr_en, ram_rd_en, ram_rd_zero;
  logic [BE_W-1:0] ram_wr_be;
  logic [IDX_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;

  assign sweep_last = (sweep_cnt == IDX_W'(DEPTH - 1));
  assign in_range   = ({1'b0, mem_addr} < DEPTH_L);
  assign accept     = mem_ready & mem_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (state == INIT && sweep_last) begin
      next_state = RUN;
    end
  end

  always_comb begin
    mem_ready = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
    end else if (state == INIT) begin
      sweep_cnt <= sweep_last ? '0 : sweep_cnt + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      mem_ack <= accept;
      mem_err <= accept & ~in_range;
    end
  end

  // During INIT the write port belongs to the sweep; afterwards to in-range writes.
  always_comb begin
    ram_wr_en   = accept & mem_wr & in_range;
    ram_wr_be   = mem_be;
    ram_wr_addr = mem_addr[IDX_W-1:0];
    ram_wr_data = mem_d_in;
    if (state == INIT) begin
      ram_wr_en   = 1'b1;
      ram_wr_be   = '1;
      ram_wr_addr = sweep_cnt;
      ram_wr_data = '0;
    end
  end

  assign ram_rd_en   = accept & ~mem_wr & in_range;
  assign ram_rd_zero = accept & ~mem_wr & ~in_range;

  dmem_byte_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (IDX_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram_wr_en),
    .wr_be   (ram_wr_be),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_zero (ram_rd_zero),
    .rd_addr (mem_addr[IDX_W-1:0]),
    .rd_data (mem_d_out)
  );

`ifdef DMEM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state == INIT) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (ram_rd_en && rd_cnt != 16'hFFFF) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (ram_wr_en && wr_cnt != 16'hFFFF) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_data_memory.sv
// Randomised + directed bench for param_data_memory against a word-array reference model.
// Instantiated with DEPTH=24 so out-of-range addresses exist; counters checked under DMEM_ACCESS_CNT_EN.
module tb_param_data_memory;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_req = 1'b0;
  logic mem_wr = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_d_in = '0;
  logic [1:0] mem_be = '0;
  logic mem_ready, mem_ack, mem_err;
  logic [DATA_W-1:0] mem_d_out;
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt, wr_cnt;
`endif

  int total = 0;
  int bad = 0;
  int notReady = 0;

  logic [15:0] modelMem [DEPTH];
  int modelSweepLeft;
  logic expAck, expErr;
  logic [15:0] expDout;
  int rdCntM, wrCntM;

  param_data_memory #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_d_in  (mem_d_in),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_ack   (mem_ack),
    .mem_d_out (mem_d_out),
    .mem_err   (mem_err)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll(input string ctx);
    checkOutput({ctx, ".ready"}, 32'(mem_ready), 32'(modelSweepLeft == 0));
    checkOutput({ctx, ".ack"}, 32'(mem_ack), 32'(expAck));
    checkOutput({ctx, ".err"}, 32'(mem_err), 32'(expErr));
    checkOutput({ctx, ".dout"}, 32'(mem_d_out), 32'(expDout));
`ifdef DMEM_ACCESS_CNT_EN
    checkOutput({ctx, ".rdcnt"}, 32'(rd_cnt), 32'(rdCntM));
    checkOutput({ctx, ".wrcnt"}, 32'(wr_cnt), 32'(wrCntM));
`endif
  endtask

  // After a full sweep every word reads zero, so the model starts from an all-zero array.
  task automatic resetModel();
    modelSweepLeft = DEPTH;
    expAck = 1'b0;
    expErr = 1'b0;
    expDout = '0;
    rdCntM = 0;
    wrCntM = 0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input int addr,
                               input logic [15:0] din, input logic [1:0] be);
    logic [15:0] mask;
    mem_req = req;
    mem_wr = wr;
    mem_addr = addr[ADDR_W-1:0];
    mem_d_in = din;
    mem_be = be;
    @(posedge clk);
    expAck = 1'b0;
    expErr = 1'b0;
    if (modelSweepLeft > 0) begin
      modelSweepLeft--;
    end else if (req) begin
      expAck = 1'b1;
      expErr = (addr >= DEPTH);
      if (wr) begin
        if (addr < DEPTH) begin
          mask = {{8{be[1]}}, {8{be[0]}}};
          modelMem[addr] = (modelMem[addr] & ~mask) | (din & mask);
          if (wrCntM < 65535) wrCntM++;
        end
      end else begin
        expDout = (addr < DEPTH) ? modelMem[addr] : 16'h0000;
        if (addr < DEPTH && rdCntM < 65535) rdCntM++;
      end
    end
    #1;
    if (!mem_ready) notReady++;
    compareAll("step");
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    #1;
    resetModel();
    compareAll("rstAsserted");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    notReady = 0;
    #1;
    if (!mem_ready) notReady++;
    compareAll("rstReleased");
  endtask

  initial begin
    $display("[TB] starting, DEPTH=%0d", DEPTH);
    #12;
    resetModel();
    compareAll("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    if (!mem_ready) notReady++;

    // Reads of addr 3 held during the sweep must be ignored until RUN.
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b1, 1'b0, 3, 16'h0, 2'b00);
    checkOutput("sweepLen", 32'(notReady), 32'(DEPTH));
    checkOutput("firstRead", 32'(mem_d_out), 32'h0000);

    applyStimulus(1'b1, 1'b1, 0, 16'h000F, 2'b11);
    applyStimulus(1'b1, 1'b0, 0, 16'h0, 2'b00);
    checkOutput("raw000F", 32'(mem_d_out), 32'h000F);

    applyStimulus(1'b1, 1'b1, 1, 16'hABCD, 2'b11);
    applyStimulus(1'b1, 1'b1, 1, 16'h1234, 2'b01);
    applyStimulus(1'b1, 1'b1, 1, 16'hFFFF, 2'b00);
    applyStimulus(1'b1, 1'b0, 1, 16'h0, 2'b00);
    checkOutput("laneAB34", 32'(mem_d_out), 32'hAB34);

    applyStimulus(1'b1, 1'b1, 25, 16'h5555, 2'b11);
    checkOutput("oorWrErr", 32'(mem_err), 32'h1);
    applyStimulus(1'b1, 1'b0, 25, 16'h0, 2'b00);
    checkOutput("oorRdData", 32'(mem_d_out), 32'h0);
    applyStimulus(1'b1, 1'b0, 23, 16'h0, 2'b00);
    checkOutput("inRangeErr", 32'(mem_err), 32'h0);

    applyStimulus(1'b1, 1'b1, 2, 16'h7E81, 2'b11);
    for (int a = 0; a < 3; a++) applyStimulus(1'b1, 1'b0, a, 16'h0, 2'b00);
    applyStimulus(1'b0, 1'b0, 0, 16'h0, 2'b00);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom % 2), int'($urandom_range(0, 31)),
                    16'($urandom), 2'($urandom % 4));
    end

    // Reset landing right after an accepted request drops the pending ack.
    applyStimulus(1'b1, 1'b0, 1, 16'h0, 2'b00);
    assertReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 4, 16'hBEEF, 2'b11);
    assertReset();
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 1'b0, 0, 16'h0, 2'b00);
    checkOutput("sweepLen2", 32'(notReady), 32'(DEPTH));
    applyStimulus(1'b1, 1'b0, 4, 16'h0, 2'b00);
    checkOutput("clearedAfterReset", 32'(mem_d_out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
